// File: rtl/alu_mdu_pkg.sv
// Shared ALU enumerations plus the multiply/divide op decode helpers.
package alu_mdu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // True for the four divide/remainder ops.
  function automatic logic is_divrem_op(mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  // True for the ops that return the remainder rather than the quotient.
  function automatic logic is_rem_op(mdu_op_e op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

  // rs1 is treated as two's complement for these ops.
  function automatic logic a_signed_op(mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  // rs2 is treated as two's complement for these ops.
  function automatic logic b_signed_op(mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Operation request / result handshake bundle for the multiply-divide unit.
interface alu_mdu_if import alu_mdu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  mdu_op_e          in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/alu_mdu_iter_core.sv
// Iterative magnitude datapath: radix-2 shift-add multiply and restoring
// shift-subtract divide, one step per clock for XLEN steps.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              start,
  input  logic              is_mul,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic              last_iter,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]     count_q;
  logic              mul_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   shift_q;
  logic [XLEN-1:0]   prem_q;
  logic [XLEN:0]     partial;
  logic [XLEN:0]     diff;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    partial = {prem_q, shift_q[XLEN-1]};
    diff    = partial - {1'b0, mcand_q[XLEN-1:0]};
  end

  // Load on start, then one multiply or divide step per cycle until the counter empties
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      mul_q   <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      shift_q <= '0;
      prem_q  <= '0;
    end else if (abort) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= CW'(XLEN);
      mul_q   <= is_mul;
      acc_q   <= '0;
      prem_q  <= '0;
      mcand_q <= {{XLEN{1'b0}}, (is_mul ? a_mag : b_mag)};
      shift_q <= is_mul ? b_mag : a_mag;
    end else if (count_q != '0) begin
      count_q <= count_q - CW'(1);
      if (mul_q) begin
        if (shift_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q <= mcand_q << 1;
        shift_q <= shift_q >> 1;
      end else if (!diff[XLEN]) begin
        prem_q  <= diff[XLEN-1:0];
        shift_q <= {shift_q[XLEN-2:0], 1'b1};
      end else begin
        prem_q  <= partial[XLEN-1:0];
        shift_q <= {shift_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign last_iter = (count_q == CW'(1));
  assign product   = acc_q;
  assign quotient  = shift_q;
  assign remainder = prem_q;

endmodule

// File: rtl/alu_mdu.sv
// Multiply/divide unit: FSM, handshake, divide special cases and sign fix-up
// around the iterative magnitude core.
module alu_mdu import alu_mdu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  alu_mdu_if.slave bus
);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q;
  mdu_state_e        state_d;
  logic              accept;
  logic              core_start;
  logic              last_iter;
  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic              op_divrem;
  logic              op_rem;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   special_res;
  mdu_op_e           op_q;
  logic              neg_q;
  logic              rem_neg_q;
  logic              special_q;
  logic [XLEN-1:0]   special_res_q;
  logic [TAG_W-1:0]  tag_q;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] product_fix;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [XLEN-1:0]   quotient_fix;
  logic [XLEN-1:0]   remainder_fix;
  logic [XLEN-1:0]   result;

  assign bus.in_ready = (state_q == MDU_IDLE);
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign core_start   = accept && !special;

  // Decode the offered op: signedness, operand magnitudes and the divide cases that skip the core
  always_comb begin
    a_signed    = a_signed_op(bus.in_op);
    b_signed    = b_signed_op(bus.in_op);
    op_divrem   = is_divrem_op(bus.in_op);
    op_rem      = is_rem_op(bus.in_op);
    a_neg       = a_signed && bus.in_a[XLEN-1];
    b_neg       = b_signed && bus.in_b[XLEN-1];
    a_mag       = a_neg ? ({XLEN{1'b0}} - bus.in_a) : bus.in_a;
    b_mag       = b_neg ? ({XLEN{1'b0}} - bus.in_b) : bus.in_b;
    div_zero    = op_divrem && (bus.in_b == '0);
    div_ovf     = op_divrem && a_signed && (bus.in_a == MOST_NEG) && (bus.in_b == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = op_rem ? bus.in_a : '1;
    end else if (div_ovf) begin
      special_res = op_rem ? '0 : bus.in_a;
    end
  end

  // Capture the op, sign fix-up flags, any special-case result and the tag on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q          <= MDU_MUL;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      tag_q         <= '0;
    end else if (accept) begin
      op_q          <= bus.in_op;
      neg_q         <= a_neg ^ b_neg;
      rem_neg_q     <= a_neg;
      special_q     <= special;
      special_res_q <= special_res;
      tag_q         <= bus.in_tag;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MDU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush wins over everything, special divides jump straight to DONE
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE: if (bus.in_valid) state_d = special ? MDU_DONE : MDU_BUSY;
        MDU_BUSY: if (last_iter) state_d = MDU_DONE;
        MDU_DONE: if (bus.out_ready) state_d = MDU_IDLE;
        default:  state_d = MDU_IDLE;
      endcase
    end
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .reset     (reset),
    .abort     (flush),
    .start     (core_start),
    .is_mul    (!op_divrem),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .last_iter (last_iter),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Apply the final two's-complement negate and pick the half or result the op asks for
  always_comb begin
    product_fix   = neg_q ? ({(2*XLEN){1'b0}} - product) : product;
    quotient_fix  = neg_q ? ({XLEN{1'b0}} - quotient) : quotient;
    remainder_fix = rem_neg_q ? ({XLEN{1'b0}} - remainder) : remainder;
    case (op_q)
      MDU_MUL:                        result = product_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: result = product_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              result = quotient_fix;
      default:                        result = remainder_fix;
    endcase
  end

  assign bus.out_valid  = (state_q == MDU_DONE);
  assign bus.out_result = bus.out_valid ? (special_q ? special_res_q : result) : '0;
  assign bus.out_tag    = tag_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed cases with literal results plus a random phase,
// all watched by a cycle-level reference model.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_mdu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  alu_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, reports a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference result straight from the arithmetic definition of each op
  function automatic logic [31:0] modelResult(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    r  = '0;
    case (op)
      MDU_MUL:    begin p = sa * sb; r = p[31:0];  end
      MDU_MULH:   begin p = sa * sb; r = p[63:32]; end
      MDU_MULHSU: begin p = sa * ub; r = p[63:32]; end
      MDU_MULHU:  begin p = ua * ub; r = p[63:32]; end
      MDU_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      MDU_DIVU: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      MDU_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  // Cycles from the accepting cycle to the first cycle with out_valid
  function automatic int modelLatency(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic divrem, ovf;
    divrem = (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
    ovf    = ((op == MDU_DIV) || (op == MDU_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    return (divrem && (b == 0 || ovf)) ? 1 : XLEN + 1;
  endfunction

  // Model of the unit: one op in flight, result due at a known cycle, held until taken
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_due = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_tag = '0;
  bit          exp_valid;

  // Compare the DUT against the model every cycle, then advance the model on the inputs seen
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 1'b0;
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_out_result", bus.out_result, 0);
      checkOutput("rst_out_tag", bus.out_tag, 0);
    end else begin
      exp_valid = m_busy && (cyc >= m_due);
      checkOutput("mon_in_ready", bus.in_ready, !m_busy);
      checkOutput("mon_out_valid", bus.out_valid, exp_valid);
      if (exp_valid) begin
        checkOutput("mon_out_result", bus.out_result, m_res);
        checkOutput("mon_out_tag", bus.out_tag, m_tag);
      end
      if (flush) begin
        m_busy = 1'b0;
      end else if (!m_busy && bus.in_valid) begin
        m_busy = 1'b1;
        m_due  = cyc + modelLatency(bus.in_op, bus.in_a, bus.in_b);
        m_res  = modelResult(bus.in_op, bus.in_a, bus.in_b);
        m_tag  = bus.in_tag;
      end else if (exp_valid && bus.out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Offer one op for a single accepting edge; caller guarantees the unit is idle
  task automatic applyStimulus(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Run one op to completion with literal expectations, optionally holding the result first
  task automatic runOp(input string name, input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp_res, input int exp_lat, input int hold);
    int  lat;
    bit  saw_ready;
    logic [31:0] held_res;
    applyStimulus(op, a, b, tag);
    lat       = 1;
    saw_ready = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_ready_while_busy"}, saw_ready, 0);
    checkOutput({name, "_result"}, bus.out_result, exp_res);
    checkOutput({name, "_tag"}, bus.out_tag, tag);
    held_res = bus.out_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({name, "_hold_valid"}, bus.out_valid, 1);
      checkOutput({name, "_hold_result"}, bus.out_result, held_res);
      checkOutput({name, "_hold_tag"}, bus.out_tag, tag);
      checkOutput({name, "_hold_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({name, "_idle_ready"}, bus.in_ready, 1);
    checkOutput({name, "_idle_valid"}, bus.out_valid, 0);
  endtask

  // Operand generator biased toward the corner values of the divide rules
  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Hard stop if something wedges the run
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases, flush/reset aborts, then a random phase
  initial begin
    bit saw_valid;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = MDU_MUL;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    checkOutput("pin_model_mul", modelResult(MDU_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    checkOutput("pin_model_mulhsu", modelResult(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    checkOutput("pin_model_rem", modelResult(MDU_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    checkOutput("pin_model_remu", modelResult(MDU_REMU, 32'd100, 32'd7), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    reset = 1'b0;
    checkOutput("reset_release_ready", bus.in_ready, 1);

    runOp("mul_7_m3",   MDU_MUL,   32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33, 0);
    runOp("mulh_min",   MDU_MULH,  32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 33, 0);
    runOp("mulhu_ones", MDU_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33, 0);
    runOp("div_m7_2",   MDU_DIV,   32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFD, 33, 0);
    runOp("rem_m7_2",   MDU_REM,   32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFF, 33, 0);
    runOp("divu_ones",  MDU_DIVU,  32'hFFFF_FFFF,  32'h10,        5'd8,  32'h0FFF_FFFF, 33, 0);
    runOp("div_by0",    MDU_DIV,   32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1, 0);
    runOp("rem_by0",    MDU_REM,   32'd5,          32'd0,         5'd10, 32'd5,         1, 0);
    runOp("div_ovf",    MDU_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 0);
    runOp("hold_mul",   MDU_MUL,   32'd1000,       32'd1000,      5'd21, 32'd1000000,   33, 10);

    applyStimulus(MDU_MUL, 32'd12345, 32'd678, 5'd12);
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("flush_busy_ready", bus.in_ready, 0);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = MDU_DIVU;
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_next_ready", bus.in_ready, 1);
    saw_valid = 1'b0;
    repeat (40) begin
      if (bus.out_valid) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("flush_no_valid", saw_valid, 0);

    applyStimulus(MDU_DIV, 32'd999, 32'd7, 5'd13);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst_busy_next_ready", bus.in_ready, 1);
    saw_valid = 1'b0;
    repeat (40) begin
      if (bus.out_valid) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("rst_busy_no_valid", saw_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.in_op     = mdu_op_e'($urandom_range(0, 7));
      bus.in_a      = pickOperand();
      bus.in_b      = pickOperand();
      bus.in_tag    = 5'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 49) == 0);
      reset         = ($urandom_range(0, 399) == 0);
      @(posedge clk); #1;
    end

    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (50) begin @(posedge clk); #1; end
    checkOutput("drain_idle", bus.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 The module SHALL take parameter XLEN, default 32, as the operand and result width; legal values are 32 and 64.
REQ-002 The module SHALL take parameter TAG_W, default 5, as the width of the destination-register tag carried with each operation.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset; one clock, reset asynchronous active-high.
REQ-005 The module SHALL have port flush, input, 1 bit: synchronous abort of any in-flight or held operation.
REQ-006 The module SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the unit accepts an operation this cycle.
REQ-008 The module SHALL have port in_op, input, mdu_op_e (3 bits): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-009 The module SHALL have ports in_a and in_b, input, XLEN bits each: rs1 and rs2 operands.
REQ-010 The module SHALL have port in_tag, input, TAG_W bits: destination register.
REQ-011 The module SHALL have port out_valid, output, 1 bit: a result is held.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 The module SHALL have ports out_result (XLEN bits) and out_tag (TAG_W bits), outputs: the result and its tag.

Function
REQ-014 The module SHALL implement three states: IDLE, BUSY and DONE.
REQ-015 The module SHALL drive in_ready=1 only in IDLE, and an accept occurs when in_valid && in_ready && !flush.
REQ-016 On accept of a normal operation, the module SHALL go IDLE->BUSY, load an iteration counter with XLEN and latch the op, operand magnitudes, sign-fixup flags and tag.
REQ-017 In BUSY, the module SHALL perform one iteration per cycle and decrement the counter: radix-2 shift-add for MUL*, restoring shift-subtract for DIV*/REM*.
REQ-018 When the counter reaches 0, the module SHALL go BUSY->DONE with out_valid=1; latency from accept edge to out_valid is XLEN+1 cycles.
REQ-019 In DONE, the module SHALL hold out_result and out_tag stable while out_ready=0, and go DONE->IDLE on out_ready=1.
REQ-020 A new operation SHALL NOT be accepted in the cycle DONE is left; back-to-back throughput is one operation per XLEN+2 cycles minimum.
REQ-021 For MUL, the result SHALL be the low XLEN bits of the 2*XLEN product; for MULH/MULHSU/MULHU it SHALL be the high XLEN bits, with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-022 DIV/REM SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-023 On divide by zero, the module SHALL go IDLE->DONE in one cycle with quotient = all ones and remainder = in_a.
REQ-024 On signed overflow (in_a = 1<<(XLEN-1), in_b = -1, DIV/REM), the module SHALL go IDLE->DONE in one cycle with quotient = in_a and remainder = 0.
REQ-025 When flush=1, the module SHALL go to IDLE next cycle from any state, drop out_valid, and ignore in_valid that same cycle.
REQ-026 Flush SHALL take priority over out_ready and over accept.
REQ-027 Internal arithmetic SHALL be performed on magnitudes with a final two's-complement negate; no X-width truncation except the final XLEN selection.

Reset
REQ-028 While reset=1, the module SHALL force state=IDLE, counter=0 and out_valid=0, with out_result and out_tag at 0.
REQ-029 Reset asserted mid-BUSY or mid-DONE SHALL discard the operation, with no output produced after release.
REQ-030 After reset release, in_ready SHALL be 1 in the first cycle.

Structure
REQ-031 mdu_op_e and the state enum SHALL live in the shared ALU enums package alongside the existing ALU op enum.
REQ-032 The iterative datapath (accumulator, partial remainder, shift register and counter) SHALL be one sub-module, mdu_iter_core, with alu_mdu owning the FSM, handshake, special cases and sign fix-up.

Verification
REQ-033 The bench SHALL cover MUL with XLEN=32, a=7, b=-3: result 0xFFFFFFEB, out_valid exactly 33 cycles after accept, and in_ready=0 throughout.
REQ-034 The bench SHALL cover MULH with a=0x80000000, b=0x80000000: result 0x40000000; and MULHU with a=b=0xFFFFFFFF: result 0xFFFFFFFE.
REQ-035 The bench SHALL cover DIV -7/2: result -3; and REM -7/2: result -1; and DIVU 0xFFFFFFFF/0x10: result 0x0FFFFFFF.
REQ-036 The bench SHALL cover DIV 5/0: result 0xFFFFFFFF; and REM 5/0: result 5; and DIV 0x80000000/-1: result 0x80000000; all with out_valid one cycle after accept.
REQ-037 The bench SHALL cover out_ready held 0 for 10 cycles in DONE: result and tag stable, in_ready=0; then out_ready=1 gives IDLE the next cycle.
REQ-038 The bench SHALL cover flush at BUSY cycle 5 together with in_valid=1: no accept, out_valid never rises, and in_ready=1 the next cycle; reset pulsed mid-BUSY gives the same outcome.
